// File: rtl/iob_wishbone_bridge_pkg.sv
// Shared types and helpers for the IOb-to-Wishbone bridge: FSM encoding,
// byte-lane index width and the all-ones error read pattern.
package iob_wishbone_bridge_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_e;

  localparam int MAX_DATA_W = 1024;

  // With a single byte lane there is no lane index; keep a 1-bit field so slices stay legal.
  function automatic int lsb_w(input int data_w);
    return (data_w > 8) ? $clog2(data_w / 8) : 1;
  endfunction

  function automatic logic [MAX_DATA_W-1:0] all_ones(input int w);
    logic [MAX_DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (i < w) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/iob_wb_sat_counter.sv
// Saturating event counter: counts inc_i pulses and sticks at all-ones.
module iob_wb_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         arst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/iob_wishbone_bridge.sv
// IOb-native slave to Wishbone classic master bridge with one outstanding
// cycle, ack/err handling, bus timeout and saturating error counters.
module iob_wishbone_bridge
  import iob_wishbone_bridge_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int SEL_MODE    = 0,
  parameter int TIMEOUT_CYC = 255,
  parameter int ERRCNT_W    = 8
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                iob_avalid_i,
  input  logic [ADDR_W-1:0]   iob_addr_i,
  input  logic [DATA_W-1:0]   iob_wdata_i,
  input  logic [DATA_W/8-1:0] iob_wstrb_i,
  output logic                iob_ready_o,
  output logic                iob_rvalid_o,
  output logic [DATA_W-1:0]   iob_rdata_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic                wb_ack_i,
  input  logic                wb_err_i,
  output logic                err_o,
  output logic [ERRCNT_W-1:0] err_cnt_o,
  output logic [ERRCNT_W-1:0] tout_cnt_o
);

  localparam int STRB_W  = DATA_W / 8;
  localparam int LSB_W   = lsb_w(DATA_W);
  localparam int TCNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit TOUT_EN = (TIMEOUT_CYC != 0);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [MAX_DATA_W-1:0] ONES_FULL = all_ones(DATA_W);
  localparam logic [DATA_W-1:0] RD_ONES = ONES_FULL[DATA_W-1:0];

  state_e              state_q, state_d;
  logic                cyc_q, cyc_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic [STRB_W-1:0]   sel_q, sel_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                err_q, err_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic                err_inc, tout_inc;

  // Narrow byte peripherals get a one-hot lane from the low address bits.
  function automatic logic [STRB_W-1:0] req_sel(input logic [ADDR_W-1:0] addr,
                                                input logic [STRB_W-1:0] wstrb);
    if (SEL_MODE == 1) begin
      if (STRB_W == 1) return '1;
      return STRB_W'(1) << addr[LSB_W-1:0];
    end
    return (wstrb == '0) ? '1 : wstrb;
  endfunction

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    we_d     = we_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    sel_d    = sel_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    tcnt_d   = tcnt_q;
    err_inc  = 1'b0;
    tout_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (iob_avalid_i) begin
          adr_d   = iob_addr_i;
          dat_d   = iob_wdata_i;
          sel_d   = req_sel(iob_addr_i, iob_wstrb_i);
          we_d    = |iob_wstrb_i;
          cyc_d   = 1'b1;
          tcnt_d  = '0;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        // err has priority over a simultaneous ack.
        if (wb_err_i) begin
          state_d = ST_IDLE;
          cyc_d   = 1'b0;
          tcnt_d  = '0;
          err_d   = 1'b1;
          err_inc = 1'b1;
          if (!we_q) begin
            rdata_d  = RD_ONES;
            rvalid_d = 1'b1;
          end
        end else if (wb_ack_i) begin
          state_d = ST_IDLE;
          cyc_d   = 1'b0;
          tcnt_d  = '0;
          if (!we_q) begin
            rdata_d  = wb_dat_i;
            rvalid_d = 1'b1;
          end
        end else if (TOUT_EN && (tcnt_q == TCNT_LAST)) begin
          state_d  = ST_IDLE;
          cyc_d    = 1'b0;
          tcnt_d   = '0;
          err_d    = 1'b1;
          tout_inc = 1'b1;
          if (!we_q) begin
            rdata_d  = RD_ONES;
            rvalid_d = 1'b1;
          end
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q  <= ST_IDLE;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      sel_q    <= sel_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      tcnt_q   <= tcnt_d;
    end
  end

  iob_wb_sat_counter #(.W(ERRCNT_W)) u_err_cnt (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .inc_i  (err_inc),
    .cnt_o  (err_cnt_o)
  );

  iob_wb_sat_counter #(.W(ERRCNT_W)) u_tout_cnt (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .inc_i  (tout_inc),
    .cnt_o  (tout_cnt_o)
  );

  assign iob_ready_o  = (state_q == ST_IDLE);
  assign iob_rvalid_o = rvalid_q;
  assign iob_rdata_o  = rdata_q;
  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = cyc_q;
  assign wb_we_o      = we_q;
  assign wb_adr_o     = adr_q;
  assign wb_sel_o     = sel_q;
  assign wb_dat_o     = dat_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_iob_wishbone_bridge.sv
// Randomised bench for the IOb-to-Wishbone bridge against a transaction-level model.
module tb_iob_wishbone_bridge;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int SW = 4;
  localparam int TO = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  logic          avalid;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          ready, rvalid;
  logic [DW-1:0] rdata;
  logic          cyc, stb, we;
  logic [AW-1:0] adr;
  logic [SW-1:0] sel;
  logic [DW-1:0] dat_o, dat_i;
  logic          ack, err;
  logic          err_o;
  logic [CW-1:0] err_cnt, tout_cnt;

  iob_wishbone_bridge #(.DATA_W(DW), .ADDR_W(AW), .SEL_MODE(0), .TIMEOUT_CYC(TO), .ERRCNT_W(CW)) u_dut (
    .clk_i(clk), .arst_i(arst),
    .iob_avalid_i(avalid), .iob_addr_i(addr), .iob_wdata_i(wdata), .iob_wstrb_i(wstrb),
    .iob_ready_o(ready), .iob_rvalid_o(rvalid), .iob_rdata_o(rdata),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_adr_o(adr), .wb_sel_o(sel),
    .wb_dat_o(dat_o), .wb_dat_i(dat_i), .wb_ack_i(ack), .wb_err_i(err),
    .err_o(err_o), .err_cnt_o(err_cnt), .tout_cnt_o(tout_cnt)
  );

  // Lane-select instances with zero-wait slaves.
  logic          s_avalid;
  logic [AW-1:0] s_addr;
  logic [SW-1:0] s_wstrb;
  logic          s_ready, s_rvalid, s_cyc, s_stb, s_we, s_ack, s_err_o;
  logic [DW-1:0] s_rdata, s_dat_o;
  logic [AW-1:0] s_adr;
  logic [SW-1:0] s_sel;
  logic [CW-1:0] s_err_cnt, s_tout_cnt;
  assign s_ack = s_cyc & s_stb;

  iob_wishbone_bridge #(.DATA_W(DW), .ADDR_W(AW), .SEL_MODE(1), .TIMEOUT_CYC(0), .ERRCNT_W(CW)) u_sel (
    .clk_i(clk), .arst_i(arst),
    .iob_avalid_i(s_avalid), .iob_addr_i(s_addr), .iob_wdata_i(32'h1234_5678), .iob_wstrb_i(s_wstrb),
    .iob_ready_o(s_ready), .iob_rvalid_o(s_rvalid), .iob_rdata_o(s_rdata),
    .wb_cyc_o(s_cyc), .wb_stb_o(s_stb), .wb_we_o(s_we), .wb_adr_o(s_adr), .wb_sel_o(s_sel),
    .wb_dat_o(s_dat_o), .wb_dat_i(32'h0BAD_F00D), .wb_ack_i(s_ack), .wb_err_i(1'b0),
    .err_o(s_err_o), .err_cnt_o(s_err_cnt), .tout_cnt_o(s_tout_cnt)
  );

  logic          b_ready, b_rvalid, b_cyc, b_stb, b_we, b_ack, b_err_o;
  logic [7:0]    b_rdata, b_dat_o;
  logic [AW-1:0] b_adr;
  logic [0:0]    b_sel;
  logic [CW-1:0] b_err_cnt, b_tout_cnt;
  assign b_ack = b_cyc & b_stb;

  iob_wishbone_bridge #(.DATA_W(8), .ADDR_W(AW), .SEL_MODE(1), .TIMEOUT_CYC(8), .ERRCNT_W(CW)) u_b8 (
    .clk_i(clk), .arst_i(arst),
    .iob_avalid_i(s_avalid), .iob_addr_i(s_addr), .iob_wdata_i(8'h5A), .iob_wstrb_i(s_wstrb[0]),
    .iob_ready_o(b_ready), .iob_rvalid_o(b_rvalid), .iob_rdata_o(b_rdata),
    .wb_cyc_o(b_cyc), .wb_stb_o(b_stb), .wb_we_o(b_we), .wb_adr_o(b_adr), .wb_sel_o(b_sel),
    .wb_dat_o(b_dat_o), .wb_dat_i(8'hC3), .wb_ack_i(b_ack), .wb_err_i(1'b0),
    .err_o(b_err_o), .err_cnt_o(b_err_cnt), .tout_cnt_o(b_tout_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level model state
  logic [DW-1:0] m_rdata;
  int            m_errs, m_touts;

  function automatic logic [CW-1:0] sat(input int v);
    return (v > 255) ? 8'hFF : CW'(v);
  endfunction

  // kind: 0 = ack, 1 = err, 2 = ack+err; delay >= TO means the slave never answers in time.
  task automatic run_txn(input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic [SW-1:0] ws,
                         input int delay, input int kind, input logic [DW-1:0] sdat);
    int n;
    int exp_n;
    bit is_rd, resp, exp_err;
    logic [SW-1:0] esel;
    is_rd = (ws == '0);
    esel  = is_rd ? '1 : ws;
    resp  = (delay < TO);
    exp_n = resp ? delay + 1 : TO;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b exp 1", ready); end
    avalid = 1'b1; addr = a; wdata = wd; wstrb = ws;
    @(posedge clk); #1;
    avalid = 1'b0; addr = AW'($urandom); wdata = $urandom; wstrb = SW'($urandom);
    n = 0;
    @(negedge clk);
    while (cyc === 1'b1 && n < 20) begin
      checks++;
      if ({stb, we, adr, sel, dat_o, ready} !== {1'b1, !is_rd, a, esel, wd, 1'b0}) begin
        errors++;
        $display("FAIL bus_fields got stb=%b we=%b adr=%h sel=%h dat=%h rdy=%b exp stb=1 we=%b adr=%h sel=%h dat=%h rdy=0",
                 stb, we, adr, sel, dat_o, ready, !is_rd, a, esel, wd);
      end
      if (n == delay) begin
        ack = (kind != 1); err = (kind != 0); dat_i = sdat;
      end else begin
        ack = 1'b0; err = 1'b0; dat_i = $urandom;
      end
      n++;
      @(negedge clk);
    end
    ack = 1'b0; err = 1'b0;
    if (resp && kind == 0) begin
      exp_err = 1'b0;
      if (is_rd) m_rdata = sdat;
    end else begin
      exp_err = 1'b1;
      if (resp) m_errs++; else m_touts++;
      if (is_rd) m_rdata = '1;
    end
    checks++;
    if (n != exp_n) begin errors++; $display("FAIL stb_cycles got %0d exp %0d", n, exp_n); end
    checks++;
    if ({rvalid, err_o} !== {is_rd, exp_err}) begin
      errors++; $display("FAIL term_pulses got rvalid=%b err_o=%b exp %b %b", rvalid, err_o, is_rd, exp_err);
    end
    checks++;
    if (rdata !== m_rdata) begin errors++; $display("FAIL rdata got %h exp %h", rdata, m_rdata); end
    checks++;
    if ({err_cnt, tout_cnt} !== {sat(m_errs), sat(m_touts)}) begin
      errors++; $display("FAIL counters got err=%0d tout=%0d exp %0d %0d", err_cnt, tout_cnt, sat(m_errs), sat(m_touts));
    end
    @(negedge clk);
    checks++;
    if ({rvalid, err_o, cyc, rdata} !== {1'b0, 1'b0, 1'b0, m_rdata}) begin
      errors++; $display("FAIL after_term got rvalid=%b err_o=%b cyc=%b rdata=%h exp 0 0 0 %h", rvalid, err_o, cyc, rdata, m_rdata);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({cyc, stb, we, adr, sel, dat_o, rdata, rvalid, err_o, err_cnt, tout_cnt, ready} !== {3'b0, 16'h0, 4'h0, 32'h0, 32'h0, 2'b0, 8'h0, 8'h0, 1'b1}) begin
      errors++; $display("FAIL reset_state got cyc=%b we=%b adr=%h sel=%h rdata=%h rv=%b eo=%b ec=%0d tc=%0d rdy=%b exp all zero rdy=1",
                         cyc, we, adr, sel, rdata, rvalid, err_o, err_cnt, tout_cnt, ready);
    end
    @(negedge clk); arst = 1'b0;
  endtask

  task automatic test_read_zero_wait();
    run_txn(16'h0010, 32'h0, 4'h0, 0, 0, 32'hDEAD_BEEF);
  endtask

  task automatic test_write_wait3();
    run_txn(16'h0020, 32'h0000_A5A5, 4'b0011, 3, 0, 32'h0);
  endtask

  task automatic test_ack_err();
    run_txn(16'h0030, 32'h0, 4'h0, 0, 2, 32'h1111_2222);
  endtask

  task automatic test_timeout();
    run_txn(16'h0040, 32'h0, 4'h0, 9, 0, 32'h3333_4444);
  endtask

  task automatic test_idle_ack();
    @(negedge clk);
    ack = 1'b1; err = 1'b1; dat_i = 32'h5555_6666;
    repeat (3) @(negedge clk);
    checks++;
    if ({cyc, rvalid, err_o, rdata, err_cnt, tout_cnt} !== {3'b0, m_rdata, sat(m_errs), sat(m_touts)}) begin
      errors++; $display("FAIL idle_ack got cyc=%b rv=%b eo=%b rdata=%h ec=%0d tc=%0d", cyc, rvalid, err_o, rdata, err_cnt, tout_cnt);
    end
    ack = 1'b0; err = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [SW-1:0] ws;
      ws = ($urandom_range(0, 1) == 1) ? SW'($urandom_range(1, 15)) : '0;
      run_txn(AW'($urandom), $urandom, ws, $urandom_range(0, 5), $urandom_range(0, 2), $urandom);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      run_txn(AW'($urandom), $urandom, SW'($urandom_range(0, 15)), TO + 2, 0, 32'h0);
    end
    checks++;
    if (tout_cnt !== 8'hFF) begin errors++; $display("FAIL tout_saturated got %0d exp 255", tout_cnt); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    avalid = 1'b1; addr = 16'h0050; wstrb = '0;
    @(posedge clk); #1 avalid = 1'b0;
    @(negedge clk);
    checks++;
    if (cyc !== 1'b1) begin errors++; $display("FAIL arst_pre_bus got cyc=%b exp 1", cyc); end
    #2 arst = 1'b1;
    #1;
    checks++;
    if ({cyc, stb, ready, err_cnt, tout_cnt} !== {1'b0, 1'b0, 1'b1, 8'h0, 8'h0}) begin
      errors++; $display("FAIL arst_async got cyc=%b stb=%b rdy=%b ec=%0d tc=%0d exp 0 0 1 0 0", cyc, stb, ready, err_cnt, tout_cnt);
    end
    @(posedge clk); #2 arst = 1'b0;
    m_errs = 0; m_touts = 0; m_rdata = '0;
    @(negedge clk);
    checks++;
    if ({rvalid, cyc, ready, rdata, err_cnt, tout_cnt} !== {1'b0, 1'b0, 1'b1, 32'h0, 8'h0, 8'h0}) begin
      errors++; $display("FAIL arst_after got rv=%b cyc=%b rdy=%b rdata=%h ec=%0d tc=%0d", rvalid, cyc, ready, rdata, err_cnt, tout_cnt);
    end
    run_txn(16'h0060, 32'h0, 4'h0, 1, 0, 32'hCAFE_0001);
  endtask

  task automatic test_sel_mode();
    for (int i = 0; i < 8; i++) begin
      logic [AW-1:0] a;
      logic [SW-1:0] ws;
      logic [SW-1:0] esel;
      a    = (i == 0) ? 16'h0003 : AW'($urandom);
      ws   = (i % 2 == 1) ? SW'($urandom_range(1, 15)) : '0;
      esel = SW'(1) << a[1:0];
      @(negedge clk);
      s_avalid = 1'b1; s_addr = a; s_wstrb = ws;
      @(posedge clk); #1 s_avalid = 1'b0;
      @(negedge clk);
      checks++;
      if ({s_cyc, s_sel, s_we, s_dat_o} !== {1'b1, esel, ws != '0, 32'h1234_5678}) begin
        errors++; $display("FAIL sel32 got cyc=%b sel=%b we=%b dat=%h exp 1 %b %b 12345678", s_cyc, s_sel, s_we, s_dat_o, esel, ws != '0);
      end
      checks++;
      if ({b_cyc, b_sel} !== 2'b11) begin errors++; $display("FAIL sel8 got cyc=%b sel=%b exp 1 1", b_cyc, b_sel); end
      @(negedge clk);
      checks++;
      if ({s_cyc, s_ready, s_rvalid} !== {1'b0, 1'b1, ws == '0}) begin
        errors++; $display("FAIL sel_term got cyc=%b rdy=%b rv=%b", s_cyc, s_ready, s_rvalid);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    arst = 1'b1; avalid = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    ack = 1'b0; err = 1'b0; dat_i = '0;
    s_avalid = 1'b0; s_addr = '0; s_wstrb = '0;
    m_rdata = '0; m_errs = 0; m_touts = 0;
    test_reset();
    test_read_zero_wait();
    test_write_wait3();
    test_ack_err();
    test_timeout();
    test_idle_ack();
    test_random();
    test_sel_mode();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iob_wishbone_bridge.md
Name: iob_wishbone_bridge

Overview:
Parametrised IOb-native slave to Wishbone classic master bridge. It is the successor to the fixed 8-bit UART wrapper, so any Wishbone peripheral can be attached to the IOb system bus.
- Registers each request and runs a single-outstanding Wishbone cycle.
- Returns read data with an IOb rvalid pulse.
- Adds a bus-timeout abort, ack/err handling and saturating error counters.

Parameters:
DATA_W, 32, IOb/Wishbone data width; multiple of 8, minimum 8
ADDR_W, 16, Wishbone address width (byte address)
SEL_MODE, 0, 0: wb_sel_o from wstrb (write) or all-ones (read); 1: one-hot lane from addr[log2(DATA_W/8)-1:0] (narrow byte peripherals)
TIMEOUT_CYC, 255, cycles in BUS before abort; 0 disables timeout
ERRCNT_W, 8, width of error/timeout counters

Ports:
clk_i  in  1  clock
arst_i  in  1  reset, asynchronous, active-high
iob_avalid_i  in  1  request valid
iob_addr_i  in  ADDR_W  byte address
iob_wdata_i  in  DATA_W  write data
iob_wstrb_i  in  DATA_W/8  write strobes; all-zero = read
iob_ready_o  out  1  request accepted this cycle when high with avalid
iob_rvalid_o  out  1  read data valid, one-cycle pulse
iob_rdata_o  out  DATA_W  read data, held until next read completes
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  write enable
wb_adr_o  out  ADDR_W  address
wb_sel_o  out  DATA_W/8  byte select
wb_dat_o  out  DATA_W  write data
wb_dat_i  in  DATA_W  read data
wb_ack_i  in  1  acknowledge
wb_err_i  in  1  bus error
err_o  out  1  one-cycle pulse on err or timeout termination
err_cnt_o  out  ERRCNT_W  saturating count of wb_err terminations
tout_cnt_o  out  ERRCNT_W  saturating count of timeouts

Behaviour:
- Reset values: state IDLE; cyc/stb/we = 0; adr/dat/sel = 0; rdata = 0; rvalid = 0; err_o = 0; both counters = 0. iob_ready_o = 1 (combinational from state).
- Reset asserted mid-cycle: cyc/stb drop immediately (asynchronous), no rvalid, counters cleared.
- FSM states: IDLE, BUS.
- IDLE:
  - iob_ready_o = 1.
  - On avalid, latch addr, wdata, sel; we = |wstrb. Next state BUS; cyc and stb high from the next cycle.
- BUS:
  - iob_ready_o = 0; cyc = stb = 1; adr/dat/sel/we stable.
  - Timeout counter counts from 0 every cycle in BUS.
- Termination in BUS, evaluated at the clock edge:
  - ack_i = 1, err_i = 0: on a read, rdata <= wb_dat_i and rvalid pulses next cycle. On a write, no rvalid.
  - err_i = 1, including simultaneous with ack: treated as error. A read returns rdata = all-ones with rvalid. err_o pulses; err_cnt_o increments.
  - Timeout (TIMEOUT_CYC != 0 and counter == TIMEOUT_CYC-1 with no ack/err): abort. A read returns all-ones with rvalid. err_o pulses; tout_cnt_o increments.
  - Any termination deasserts cyc/stb on that edge and returns to IDLE. The timeout counter clears.
- Latency with zero-wait slave (ack in first BUS cycle):
  - Request cycle N, stb cycles N+1, rvalid cycle N+2.
  - Next request accepted in N+2, so back-to-back throughput is 1 per 2 cycles.
- Ack/err while in IDLE is ignored (no state change, no counting).
- Counters saturate at 2^ERRCNT_W-1; no wrap.
- SEL_MODE=1: sel = 1 << addr[LSB_W-1:0] for both reads and writes; write data is passed unshifted. With DATA_W=8, sel = 1'b1.

Decomposition:
- Package iob_wishbone_bridge_pkg holds:
  - state encoding (IDLE = 1'b0, BUS = 1'b1)
  - LSB_W = $clog2(DATA_W/8), with a guard for DATA_W = 8
  - all-ones read-data constant width function
- One sub-module, iob_wb_sat_counter (parameter W; ports clk_i, arst_i, inc_i, cnt_o), instantiated twice for err and timeout counts.

Test Plan:
- Read, DATA_W=32, slave acks on first stb cycle with dat_i=32'hDEADBEEF, addr=0x10 -> stb for 1 cycle, sel=4'hF, we=0, rvalid at N+2 with rdata=32'hDEADBEEF, ready low only in N+1.
- Write, wstrb=4'b0011, wdata=32'h0000A5A5, slave acks after 3 wait cycles -> we=1, sel=4'b0011, cyc/stb held 4 cycles, no rvalid, err_o=0.
- Read, slave asserts ack and err together -> rvalid with rdata=32'hFFFFFFFF, err_o pulse, err_cnt_o=1, tout_cnt_o=0.
- TIMEOUT_CYC=4, slave never responds -> cyc/stb high exactly 4 cycles then drop, rvalid with all-ones, tout_cnt_o=1; 300 repeats -> tout_cnt_o=255 (saturated).
- SEL_MODE=1, DATA_W=32, read at addr=0x3 -> sel=4'b1000; with DATA_W=8 -> sel=1'b1.
- arst_i pulsed during BUS of a read -> cyc/stb low asynchronously, no rvalid, counters 0, ready=1 after release.
